// File: rtl/router_pkg.sv
// Shared constants and helpers for the router blocks (fsm, fifo, synchroniser).
// The watchdog action enum is shared so every port decodes it the same way.
package router_pkg;

    localparam int NUM_PORTS_DEF = 3;
    localparam int TIMEOUT_DEF   = 30;

    typedef enum logic [1:0] {
        WD_CLEAR,
        WD_COUNT,
        WD_FIRE
    } wdog_act_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

    // A single-port router still needs a one-bit address field.
    function automatic int addr_width(input int num_ports);
        return (clog2(num_ports) > 1) ? clog2(num_ports) : 1;
    endfunction

    localparam int ADDR_W_DEF = addr_width(NUM_PORTS_DEF);

endpackage

// File: rtl/router_sync_n_if.sv
// Bundle between router_fsm/router_reg, the output FIFOs and router_sync_n.
// The synchroniser uses the slave view; the driving side uses master.
interface router_sync_n_if
    import router_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int ADDR_W    = addr_width(NUM_PORTS)
) ();

    logic                 detect_add;
    logic [ADDR_W-1:0]    data_in;
    logic                 write_enb_reg;
    logic [NUM_PORTS-1:0] read_enb;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] write_enb;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] vld_out;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 addr_err;

    modport master (
        output detect_add, data_in, write_enb_reg, read_enb, empty, full,
        input  write_enb, fifo_full, vld_out, soft_reset, addr_err
    );

    modport slave (
        input  detect_add, data_in, write_enb_reg, read_enb, empty, full,
        output write_enb, fifo_full, vld_out, soft_reset, addr_err
    );

endinterface

// File: rtl/router_sync_wdog.sv
// Read-timeout watchdog for one output port: pulses o_soft_reset for one cycle
// after TIMEOUT consecutive idle cycles, then starts counting again from zero.
module router_sync_wdog
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TIMER_W = clog2(TIMEOUT + 1)
) (
    input  logic clock,
    input  logic resetn,
    input  logic i_idle,
    output logic o_soft_reset
);

    localparam logic [TIMER_W-1:0] LAST_CNT = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] r_cnt;
    logic               r_soft_reset;
    wdog_act_e          w_act;

    // NOTE: default assigned before any branch so no path leaves w_act unassigned (no latch).
    always_comb begin
        w_act = WD_CLEAR;
        if (i_idle) begin
            w_act = (r_cnt == LAST_CNT) ? WD_FIRE : WD_COUNT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt        <= '0;
            r_soft_reset <= 1'b0;
        end else begin
            unique case (w_act)
                WD_COUNT: begin
                    r_cnt        <= r_cnt + TIMER_W'(1);
                    r_soft_reset <= 1'b0;
                end
                WD_FIRE: begin
                    r_cnt        <= '0;
                    r_soft_reset <= 1'b1;
                end
                default: begin
                    r_cnt        <= '0;
                    r_soft_reset <= 1'b0;
                end
            endcase
        end
    end

    assign o_soft_reset = r_soft_reset;

endmodule

// File: rtl/router_sync_n.sv
// N-port router synchroniser: latches the header address, steers the FSM write
// strobe to one FIFO, muxes back its full flag and watches each port for read timeouts.
module router_sync_n
    import router_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int ADDR_W    = addr_width(NUM_PORTS),
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int TIMER_W   = clog2(TIMEOUT + 1)
) (
    input  logic           clock,
    input  logic           resetn,
    router_sync_n_if.slave bus
);

    logic [ADDR_W-1:0]    r_addr;
    logic                 r_addr_vld;
    logic                 r_addr_err;
    logic                 w_addr_in_range;
    logic [NUM_PORTS-1:0] w_sel;
    logic [NUM_PORTS-1:0] w_idle;

    assign w_addr_in_range = (int'(bus.data_in) < NUM_PORTS);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_addr     <= '0;
            r_addr_vld <= 1'b0;
            r_addr_err <= 1'b0;
        end else if (bus.detect_add) begin
            r_addr     <= bus.data_in;
            r_addr_vld <= w_addr_in_range;
            r_addr_err <= ~w_addr_in_range;
        end else begin
            r_addr_err <= 1'b0;
        end
    end

    // One-hot port select; all zero for an out-of-range address so its bytes are dropped.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_sel[i] = r_addr_vld && (int'(r_addr) == i);
        end
    end

    assign bus.write_enb = w_sel & {NUM_PORTS{bus.write_enb_reg}};
    assign bus.fifo_full = |(w_sel & bus.full);
    assign bus.vld_out   = ~bus.empty;
    assign bus.addr_err  = r_addr_err;
    assign w_idle        = ~bus.empty & ~bus.read_enb;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_wdog
        router_sync_wdog #(
            .TIMEOUT (TIMEOUT),
            .TIMER_W (TIMER_W)
        ) u_wdog (
            .clock        (clock),
            .resetn       (resetn),
            .i_idle       (w_idle[g]),
            .o_soft_reset (bus.soft_reset[g])
        );
    end

endmodule

// File: tb/tb_router_sync_n.sv
// Bench for router_sync_n: a 3-port/TIMEOUT=30 and an 8-port/TIMEOUT=4 instance,
// directed scenarios then random traffic, checked against an idle-streak model.
module tb_router_sync_n;
    import router_pkg::*;

    localparam int NA  = 3;
    localparam int TA  = 30;
    localparam int AWA = addr_width(NA);
    localparam int NB  = 8;
    localparam int TB  = 4;
    localparam int AWB = addr_width(NB);

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    router_sync_n_if #(.NUM_PORTS(NA), .ADDR_W(AWA)) if_a ();
    router_sync_n_if #(.NUM_PORTS(NB), .ADDR_W(AWB)) if_b ();

    router_sync_n #(.NUM_PORTS(NA), .ADDR_W(AWA), .TIMEOUT(TA), .TIMER_W(clog2(TA + 1)))
        u_dut_a (.clock(clock), .resetn(resetn), .bus(if_a));
    router_sync_n #(.NUM_PORTS(NB), .ADDR_W(AWB), .TIMEOUT(TB), .TIMER_W(clog2(TB + 1)))
        u_dut_b (.clock(clock), .resetn(resetn), .bus(if_b));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: latched destination plus length of each port's current idle streak.
    int          np  [2] = '{NA, NB};
    int          tmo [2] = '{TA, TB};
    int          m_addr [2];
    bit          m_vld  [2];
    bit          m_err  [2];
    int          m_streak [2][16];
    logic [15:0] m_sr   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_we(input int d, input logic we_reg);
        return (m_vld[d] && we_reg) ? (16'(1) << m_addr[d]) : 16'(0);
    endfunction

    function automatic logic exp_ff(input int d, input logic [15:0] full);
        return m_vld[d] ? full[m_addr[d]] : 1'b0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_addr[d] = 0;
            m_vld[d]  = 1'b0;
            m_err[d]  = 1'b0;
            m_sr[d]   = '0;
            for (int p = 0; p < 16; p++) m_streak[d][p] = 0;
        end
    endtask

    // A pulse falls on every TIMEOUT-th cycle of an unbroken idle streak.
    task automatic model_edge(input int d, input logic det, input int din,
                              input logic [15:0] emp, input logic [15:0] rd);
        if (det) begin
            m_addr[d] = din;
            m_vld[d]  = (din < np[d]);
            m_err[d]  = (din >= np[d]);
        end else begin
            m_err[d] = 1'b0;
        end
        for (int p = 0; p < np[d]; p++) begin
            if (!emp[p] && !rd[p]) begin
                m_streak[d][p]++;
                m_sr[d][p] = ((m_streak[d][p] % tmo[d]) == 0);
            end else begin
                m_streak[d][p] = 0;
                m_sr[d][p]     = 1'b0;
            end
        end
    endtask

    task automatic check_comb();
        logic [NA-1:0] ev_a;
        logic [NB-1:0] ev_b;
        ev_a = ~if_a.empty;
        ev_b = ~if_b.empty;
        check("a.vld_out",   32'(if_a.vld_out),   32'(ev_a));
        check("a.write_enb", 32'(if_a.write_enb), 32'(exp_we(0, if_a.write_enb_reg)));
        check("a.fifo_full", 32'(if_a.fifo_full), 32'(exp_ff(0, 16'(if_a.full))));
        check("b.vld_out",   32'(if_b.vld_out),   32'(ev_b));
        check("b.write_enb", 32'(if_b.write_enb), 32'(exp_we(1, if_b.write_enb_reg)));
        check("b.fifo_full", 32'(if_b.fifo_full), 32'(exp_ff(1, 16'(if_b.full))));
    endtask

    task automatic check_seq();
        check("a.soft_reset", 32'(if_a.soft_reset), 32'(m_sr[0]));
        check("a.addr_err",   32'(if_a.addr_err),   32'(m_err[0]));
        check("b.soft_reset", 32'(if_b.soft_reset), 32'(m_sr[1]));
        check("b.addr_err",   32'(if_b.addr_err),   32'(m_err[1]));
    endtask

    // Inputs are already applied; returns 1 time unit after the rising edge.
    task automatic step();
        #1;
        check_comb();
        @(posedge clock);
        if (resetn) begin
            model_edge(0, if_a.detect_add, int'(if_a.data_in), 16'(if_a.empty), 16'(if_a.read_enb));
            model_edge(1, if_b.detect_add, int'(if_b.data_in), 16'(if_b.empty), 16'(if_b.read_enb));
        end else begin
            model_reset();
        end
        #1;
        check_seq();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic quiet();
        if_a.detect_add = 1'b0; if_a.data_in = '0; if_a.write_enb_reg = 1'b0;
        if_a.read_enb   = '0;   if_a.empty   = '1; if_a.full          = '0;
        if_b.detect_add = 1'b0; if_b.data_in = '0; if_b.write_enb_reg = 1'b0;
        if_b.read_enb   = '0;   if_b.empty   = '1; if_b.full          = '0;
    endtask

    task automatic async_reset(input int hold_cycles);
        resetn = 1'b0;
        #1;
        model_reset();
        check("rst.a.soft_reset", 32'(if_a.soft_reset), 32'(0));
        check("rst.a.write_enb",  32'(if_a.write_enb),  32'(0));
        check("rst.a.fifo_full",  32'(if_a.fifo_full),  32'(0));
        check("rst.b.write_enb",  32'(if_b.write_enb),  32'(0));
        check_seq();
        steps(hold_cycles);
        #1;
        resetn = 1'b1;
    endtask

    task automatic random_inputs(input int mode);
        logic [NA-1:0] ea, ra;
        logic [NB-1:0] eb, rb;
        for (int p = 0; p < NB; p++) begin
            logic e, r;
            case (mode)
                0:       begin e = 1'($urandom_range(0, 1));        r = 1'($urandom_range(0, 1)); end
                1:       begin e = ($urandom_range(0, 15) == 0);    r = ($urandom_range(0, 31) == 0); end
                default: begin e = 1'b0;                            r = ($urandom_range(0, 199) == 0); end
            endcase
            eb[p] = e;
            rb[p] = r;
            if (p < NA) begin
                ea[p] = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : e;
                ra[p] = r;
            end
        end
        if_a.detect_add    = ($urandom_range(0, 7) == 0);
        if_a.data_in       = AWA'($urandom_range(0, (1 << AWA) - 1));
        if_a.write_enb_reg = 1'($urandom_range(0, 1));
        if_a.full          = NA'($urandom);
        if_a.empty         = ea;
        if_a.read_enb      = ra;
        if_b.detect_add    = ($urandom_range(0, 7) == 0);
        if_b.data_in       = AWB'($urandom_range(0, (1 << AWB) - 1));
        if_b.write_enb_reg = 1'($urandom_range(0, 1));
        if_b.full          = NB'($urandom);
        if_b.empty         = eb;
        if_b.read_enb      = rb;
    endtask

    initial begin
        int mode;
        mode = 0;
        quiet();
        model_reset();
        #3;
        check("rst.a.write_enb", 32'(if_a.write_enb), 32'(0));
        check("rst.a.fifo_full", 32'(if_a.fifo_full), 32'(0));
        check_comb();
        check_seq();
        @(posedge clock);
        #2;
        resetn = 1'b1;

        // Address latch: the coincident write still uses the old (invalid) address.
        if_a.detect_add = 1'b1; if_a.data_in = 2'd2; if_a.write_enb_reg = 1'b1; if_a.full = 3'b100;
        #1;
        check("a.we_old_addr", 32'(if_a.write_enb), 32'(0));
        step();
        if_a.detect_add = 1'b0;
        #1;
        check("a.we_port2", 32'(if_a.write_enb), 32'b100);
        check("a.full_port2", 32'(if_a.fifo_full), 32'(1));
        step();

        // Re-target mid-packet.
        if_a.detect_add = 1'b1; if_a.data_in = 2'd0;
        #1;
        check("a.we_retarget_same", 32'(if_a.write_enb), 32'b100);
        step();
        if_a.detect_add = 1'b0;
        #1;
        check("a.we_retarget_next", 32'(if_a.write_enb), 32'b001);
        check("a.full_retarget", 32'(if_a.fifo_full), 32'(0));
        step();

        // Out-of-range address.
        if_a.detect_add = 1'b1; if_a.data_in = 2'd3; if_a.full = 3'b111;
        step();
        check("a.addr_err_pulse", 32'(if_a.addr_err), 32'(1));
        if_a.detect_add = 1'b0;
        #1;
        check("a.we_bad_addr", 32'(if_a.write_enb), 32'(0));
        check("a.full_bad_addr", 32'(if_a.fifo_full), 32'(0));
        step();
        check("a.addr_err_clear", 32'(if_a.addr_err), 32'(0));
        if_a.write_enb_reg = 1'b0; if_a.full = '0;

        // Port 1 left unread for TIMEOUT cycles.
        if_a.empty = 3'b101;
        steps(TA - 1);
        check("a.sr_before_timeout", 32'(if_a.soft_reset), 32'(0));
        step();
        check("a.sr_at_timeout", 32'(if_a.soft_reset), 32'b010);
        step();
        check("a.sr_one_cycle", 32'(if_a.soft_reset), 32'(0));

        // A read at cycle 29 restarts the count.
        if_a.empty = 3'b111;
        step();
        if_a.empty = 3'b101;
        steps(TA - 2);
        if_a.read_enb = 3'b010;
        step();
        if_a.read_enb = 3'b000;
        step();
        check("a.sr_read_at_29", 32'(if_a.soft_reset), 32'(0));
        steps(TA - 2);
        check("a.sr_restart_pre", 32'(if_a.soft_reset), 32'(0));
        step();
        check("a.sr_restart_fire", 32'(if_a.soft_reset), 32'b010);

        // Ports 0 and 2 together.
        if_a.empty = 3'b111;
        step();
        if_a.empty = 3'b010;
        steps(TA);
        check("a.sr_ports_0_2", 32'(if_a.soft_reset), 32'b101);

        // Reset in the middle of a count and of a packet.
        if_a.empty = 3'b111;
        if_a.detect_add = 1'b1; if_a.data_in = 2'd1;
        step();
        if_a.detect_add = 1'b0; if_a.write_enb_reg = 1'b1; if_a.full = 3'b010; if_a.empty = 3'b110;
        steps(10);
        #1;
        async_reset(2);
        steps(TA - 1);
        check("a.sr_after_rst_pre", 32'(if_a.soft_reset), 32'(0));
        step();
        check("a.sr_after_rst_fire", 32'(if_a.soft_reset), 32'b001);
        quiet();

        // 8-port address sweep.
        for (int a = 0; a < NB; a++) begin
            if_b.detect_add = 1'b1; if_b.data_in = AWB'(a); if_b.write_enb_reg = 1'b1;
            step();
            if_b.detect_add = 1'b0;
            #1;
            check($sformatf("b.sweep%0d", a), 32'(if_b.write_enb), 32'(1) << a);
            step();
        end
        if_b.write_enb_reg = 1'b0;

        // Short watchdog: all eight ports pulse every TB idle cycles.
        if_b.empty = '0;
        steps(TB - 1);
        check("b.sr_pre", 32'(if_b.soft_reset), 32'(0));
        step();
        check("b.sr_fire1", 32'(if_b.soft_reset), 32'hff);
        steps(TB - 1);
        check("b.sr_mid", 32'(if_b.soft_reset), 32'(0));
        step();
        check("b.sr_fire2", 32'(if_b.soft_reset), 32'hff);
        quiet();
        step();

        // Random traffic with occasional asynchronous resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ((cyc % 100) == 0) mode = $urandom_range(0, 2);
            random_inputs(mode);
            if ($urandom_range(0, 599) == 0) begin
                #1;
                async_reset(1);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
